one_to_eight_demux: RTL

Registered 1-to-8 distributor that takes a SIZE-bit word with a 3-bit destination select and delivers it to one of eight output lanes A..H. It is the counterpart of the eight-to-one mux: where the mux gathers eight sources onto one bus, this block fans one producer out to eight consumers. Each lane has a one-entry holding register with its own valid/acknowledge pair, so a slow consumer stalls only the producer words addressed to it.

---
 rtl/one_to_eight_demux_pkg.sv | 11 +
 rtl/one_to_eight_demux_lane.sv | 45 ++++
 rtl/one_to_eight_demux.sv | 82 ++++++++
 3 files changed

// File: rtl/one_to_eight_demux_pkg.sv
// Shared constants and lane state type for the one-to-eight demux.
package one_to_eight_demux_pkg;
  localparam int LANES        = 8;
  localparam int SEL_W        = 3;
  localparam int DEFAULT_SIZE = 16;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;
endpackage

// File: rtl/one_to_eight_demux_lane.sv
// One-entry holding register for a single demux lane, with its EMPTY/FULL FSM.
module demux_lane
  import one_to_eight_demux_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            LOAD,
  input  logic [SIZE-1:0] DIN,
  input  logic            ACK,
  output logic [SIZE-1:0] DOUT,
  output logic            VALID
);
  lane_state_t     r_state;
  logic [SIZE-1:0] r_dout;

  // A load wins over an ACK in the same cycle: the lane stays FULL with the new word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= LANE_EMPTY;
      r_dout  <= '0;
    end else begin
      case (r_state)
        LANE_EMPTY: begin
          if (LOAD) begin
            r_dout  <= DIN;
            r_state <= LANE_FULL;
          end
        end
        LANE_FULL: begin
          if (LOAD) begin
            r_dout <= DIN;
          end else if (ACK) begin
            r_state <= LANE_EMPTY;
          end
        end
        default: r_state <= LANE_EMPTY;
      endcase
    end
  end

  assign DOUT  = r_dout;
  assign VALID = (r_state == LANE_FULL);
endmodule

// File: rtl/one_to_eight_demux.sv
// Registered 1-to-8 distributor with per-lane valid/ack holding registers.
// Optional DEMUX_AUTOSEL_EN replaces SEL with a stalling round-robin pointer.
module one_to_eight_demux
  import one_to_eight_demux_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [SEL_W-1:0] SEL,
  input  logic [SIZE-1:0]  IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [SIZE-1:0]  A,
  output logic [SIZE-1:0]  B,
  output logic [SIZE-1:0]  C,
  output logic [SIZE-1:0]  D,
  output logic [SIZE-1:0]  E,
  output logic [SIZE-1:0]  F,
  output logic [SIZE-1:0]  G,
  output logic [SIZE-1:0]  H,
  output logic [LANES-1:0] VALID,
  input  logic [LANES-1:0] ACK,
  output logic [SEL_W-1:0] CUR_SEL
);
  logic [SEL_W-1:0] w_dest;
  logic             w_xfer;
  logic [LANES-1:0] w_load;
  logic [LANES-1:0] w_valid;
  logic [SIZE-1:0]  w_dout [LANES];

`ifdef DEMUX_AUTOSEL_EN
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_unused_sel;

  // Pointer only advances on an accepted word, so a FULL lane stalls rather than being skipped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign w_dest       = r_ptr;
  assign w_unused_sel = SEL;
`else
  assign w_dest = SEL;
`endif

  assign CUR_SEL  = w_dest;
  assign IN_READY = RST_N & (~w_valid[w_dest] | ACK[w_dest]);
  assign w_xfer   = IN_VALID & IN_READY;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_load[gi] = w_xfer & (w_dest == SEL_W'(gi));

      demux_lane #(
        .SIZE (SIZE)
      ) u_lane (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (w_load[gi]),
        .DIN   (IN),
        .ACK   (ACK[gi]),
        .DOUT  (w_dout[gi]),
        .VALID (w_valid[gi])
      );
    end
  endgenerate

  assign VALID = w_valid;
  assign A = w_dout[0];
  assign B = w_dout[1];
  assign C = w_dout[2];
  assign D = w_dout[3];
  assign E = w_dout[4];
  assign F = w_dout[5];
  assign G = w_dout[6];
  assign H = w_dout[7];
endmodule
